// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - APB interrupt controller with claim/complete gateway
//
// Purpose
//   Collects NUM_SRC level interrupt sources into pending bits and masks them
//   with per-source enables. The core reads CLAIM to take the lowest-numbered
//   enabled pending source (id = index + 1, 0 when none). It writes that id
//   back to CLAIM when servicing is complete. A source cannot re-pend while
//   it is in service. cpu_irq is the registered OR of enabled pending bits.
//
// Register map (byte offsets from BASE_ADDR, bits above NUM_SRC read 0)
//   0x0 PENDING   RO
//   0x4 ENABLE    RW, byte strobes honoured
//   0x8 CLAIM     read = claim, write = complete
//   0xC INSERVICE RO
//   Other addresses read 0 and ignore writes.
//
// Ports
//   APB_PCLK     sole clock, all state on the rising edge
//   APB_PRESETn  asynchronous active-low reset
//   paddr        APB address
//   pdata        APB write data
//   prdata       APB read data, registered at the access edge
//   psel, penable, pwrite  APB controls
//   pstb         write byte strobes
//   pready       high for exactly one cycle per access
//   perr         APB error, always 0
//   irq_src      level interrupt sources (bit 0 = timer_interrupt)
//   cpu_irq      registered interrupt request to the core
//
// Build option
//   INTC_SYNC_EN  when defined, each irq_src bit passes a 2-flop synchronizer
//                 before the gateway. When undefined, sources must already be
//                 synchronous to APB_PCLK.

module intr_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_SRC    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h11008000
) (
  input  logic                  APB_PCLK,
  input  logic                  APB_PRESETn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pdata,
  output logic [DATA_WIDTH-1:0] prdata,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            pstb,
  output logic                  pready,
  output logic                  perr,
  input  logic [NUM_SRC-1:0]    irq_src,
  output logic                  cpu_irq
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  localparam logic [ADDR_WIDTH-1:0] A_PENDING   = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] A_ENABLE    = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_CLAIM     = BASE_ADDR + ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] A_INSERVICE = BASE_ADDR + ADDR_WIDTH'(12);

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] inservice;
  logic [NUM_SRC-1:0] src_g;

  logic [NUM_SRC-1:0] pending_n;
  logic [NUM_SRC-1:0] enable_n;
  logic [NUM_SRC-1:0] inservice_n;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] claim_mask;
  logic [NUM_SRC-1:0] complete_mask;
  logic [NUM_SRC-1:0] set_mask;
  logic [NUM_SRC-1:0] strb_bits;
  logic [ID_W-1:0]    claim_id;
  logic [DATA_WIDTH-1:0] rdata;

  logic access;
  logic wr_en;
  logic rd_en;
  logic sel_pending;
  logic sel_enable;
  logic sel_claim;
  logic sel_inservice;

  // Only the strobes covering implemented enable bits matter.
  logic unused_strb;
  assign unused_strb = ^pstb;

  assign perr = 1'b0;

  // ------------------------------------------------------------------
  // Source conditioning
  // ------------------------------------------------------------------
`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_g = sync_q2;
`else
  assign src_g = irq_src;
`endif

  // ------------------------------------------------------------------
  // APB decode
  // ------------------------------------------------------------------
  // The access fires on the first enable-phase cycle. pready, registered
  // high by that edge, masks the second cycle so each transfer acts once.
  assign access = psel & penable & ~pready;
  assign wr_en  = access & pwrite;
  assign rd_en  = access & ~pwrite;

  assign sel_pending   = (paddr == A_PENDING);
  assign sel_enable    = (paddr == A_ENABLE);
  assign sel_claim     = (paddr == A_CLAIM);
  assign sel_inservice = (paddr == A_INSERVICE);

  // ------------------------------------------------------------------
  // Claim arbitration: lowest index among enabled pending sources wins.
  // ------------------------------------------------------------------
  assign active = pending & enable;

  always_comb begin
    claim_id   = '0;
    claim_mask = '0;
    // Walk from the top so the lowest active index is written last.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_id      = ID_W'(i + 1);
        claim_mask    = '0;
        claim_mask[i] = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    complete_mask = '0;
    strb_bits     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // A complete id outside 1..NUM_SRC matches no bit and is ignored.
      complete_mask[i] = wr_en & sel_claim & (pdata == DATA_WIDTH'(i + 1));
      strb_bits[i]     = pstb[i / 8];
    end
  end

  // A source pends only while idle. Both guards use registered state, so
  // a completion re-pends a still-high source one edge later. A claimed
  // source is blocked as soon as inservice sets.
  assign set_mask = src_g & ~pending & ~inservice;

  always_comb begin
    pending_n   = pending | set_mask;
    inservice_n = inservice & ~complete_mask;
    if (rd_en && sel_claim) begin
      pending_n   = pending_n & ~claim_mask;
      inservice_n = inservice_n | claim_mask;
    end
  end

  always_comb begin
    enable_n = enable;
    if (wr_en && sel_enable) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (strb_bits[i]) begin
          enable_n[i] = pdata[i];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Read mux
  // ------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (sel_pending) begin
      rdata = DATA_WIDTH'(pending);
    end else if (sel_enable) begin
      rdata = DATA_WIDTH'(enable);
    end else if (sel_claim) begin
      rdata = DATA_WIDTH'(claim_id);
    end else if (sel_inservice) begin
      rdata = DATA_WIDTH'(inservice);
    end
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
    if (!APB_PRESETn) begin
      pending   <= '0;
      enable    <= '0;
      inservice <= '0;
      cpu_irq   <= 1'b0;
      pready    <= 1'b0;
      prdata    <= '0;
    end else begin
      pready    <= access;
      pending   <= pending_n;
      enable    <= enable_n;
      inservice <= inservice_n;
      // Built from the registered bits, so it lags any change by one edge.
      cpu_irq   <= |(pending & enable);
      if (rd_en) begin
        prdata <= rdata;
      end
    end
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (1..31).
REQ-004 SHALL have parameter BASE_ADDR, default 'h11008000, register block base.
REQ-005 SHALL have port APB_PCLK  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port APB_PRESETn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port paddr  input  ADDR_WIDTH  APB address.
REQ-008 SHALL have port pdata  input  DATA_WIDTH  APB write data.
REQ-009 SHALL have port prdata  output  DATA_WIDTH  APB read data.
REQ-010 SHALL have ports psel, penable, pwrite  input  1 each  APB controls.
REQ-011 SHALL have port pstb  input  4  write byte strobes.
REQ-012 SHALL have port pready  output  1  APB ready.
REQ-013 SHALL have port perr  output  1  APB error, tied 0.
REQ-014 SHALL have port irq_src  input  NUM_SRC  level sources; bit 0 driven by the timer's timer_interrupt.
REQ-015 SHALL have port cpu_irq  output  1  registered interrupt request to the core.

Function
REQ-016 Register map (offset from BASE_ADDR): 0x0 PENDING (RO), 0x4 ENABLE (RW), 0x8 CLAIM (read = claim, write = complete), 0xC INSERVICE (RO); bits above NUM_SRC read 0.
REQ-017 Access: when psel && penable && !pready, block SHALL set pready=1 at the next edge and perform the access side effect at that same edge; otherwise pready=0 (one wait-free cycle, pready high exactly one cycle).
REQ-018 prdata SHALL be registered at the access edge and held until the next access; unmapped addresses read 0, writes ignored, perr stays 0.
REQ-019 ENABLE writes SHALL honor pstb per byte; PENDING/INSERVICE writes ignored.
REQ-020 Gateway per source i: pending[i] SHALL set at an edge where src_i=1, pending[i]=0 and inservice[i]=0; it stays set regardless of src_i until claimed.
REQ-021 CLAIM read SHALL return id = lowest i with pending[i]&enable[i], plus 1; returns 0 if none; at that edge pending[i] clears and inservice[i] sets.
REQ-022 CLAIM write of id k (1..NUM_SRC) SHALL clear inservice[k-1]; id 0 or out of range ignored; if src still high, pending re-sets at the following edge.
REQ-023 cpu_irq SHALL equal |(pending & enable) registered: one edge after pending/enable change.
REQ-024 Simultaneous claim of i and new assertion of src_i: claim wins; pending[i] SHALL stay 0 (inservice blocks re-set).
REQ-025 Simultaneous complete of i and src_i high: inservice clears at that edge, pending[i] sets at next edge.
REQ-026 Disabled pending sources SHALL remain pending and be visible in PENDING but not raise cpu_irq or be claimed.

Reset
REQ-027 On APB_PRESETn low, asynchronously: pending=0, enable=0, inservice=0, cpu_irq=0, pready=0, prdata=0, synchronizer flops=0.
REQ-028 Reset asserted mid-access SHALL abort it; no side effect, pready low after release until a new access.

Configuration
REQ-029 Macro INTC_SYNC_EN defined: each irq_src bit SHALL pass a 2-flop synchronizer before the gateway, adding 2 cycles of latency (src edge to cpu_irq = 4 edges).
REQ-030 Macro INTC_SYNC_EN undefined: irq_src feeds the gateway directly (src to cpu_irq = 2 edges); sources must then be APB_PCLK-synchronous.

Verification
REQ-031 ENABLE=0x1, raise irq_src[0] -> PENDING=0x1, cpu_irq=1 two edges later (four with INTC_SYNC_EN).
REQ-032 ENABLE=0xFF, raise irq_src[3] and [5] together, read CLAIM -> 4, then 6, then 0; INSERVICE=0x28; cpu_irq drops after second claim.
REQ-033 Source 0 held high, claim (reads 1), write CLAIM=1 -> INSERVICE=0, PENDING=0x1 one edge later, cpu_irq reasserts.
REQ-034 ENABLE=0x0, raise irq_src[2] -> PENDING=0x4, cpu_irq=0, CLAIM reads 0; then write ENABLE=0x4 with pstb=4'b0001 -> cpu_irq=1.
REQ-035 Write CLAIM=0 and CLAIM=9 -> no state change; read 0x11008010 -> prdata=0, perr=0, pready one cycle.
REQ-036 Assert APB_PRESETn low during access phase with PENDING=0x3 -> all registers 0 immediately, pready stays 0 after release.
